// File: rtl/mac_frame_generator_if.sv
// Handshake and TX word bus of the MAC frame generator.
// The slave modport belongs to the generator; the master side requests frames and watches the TX words.
interface mac_frame_generator_if;
    logic        i_start;
    logic [15:0] i_payload_len;
    logic [7:0]  i_seed;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_data_valid;
    logic        o_busy;
    logic        o_frame_done;
    logic [15:0] o_frame_count;

    modport master (
        output i_start, i_payload_len, i_seed,
        input  o_tx_data, o_tx_ctrl, o_data_valid, o_busy, o_frame_done, o_frame_count
    );

    modport slave (
        input  i_start, i_payload_len, i_seed,
        output o_tx_data, o_tx_ctrl, o_data_valid, o_busy, o_frame_done, o_frame_count
    );
endinterface

// File: rtl/mac_frame_generator.sv
// Transmit-side MAC frame source: one START..TERM frame per accepted start, 64-bit data + 8-bit ctrl words.
// Every frame byte is derived from its absolute byte index, so FCS and TERM land wherever the length puts them.
module mac_frame_generator #(
    parameter int          DATA_WIDTH    = 64,
    parameter int          CTRL_WIDTH    = 8,
    parameter logic [7:0]  IDLE_CODE     = 8'h07,
    parameter logic [7:0]  START_CODE    = 8'hFB,
    parameter logic [7:0]  TERM_CODE     = 8'hFD,
    parameter logic [7:0]  PREAMBLE_CODE = 8'h55,
    parameter logic [7:0]  SFD_CODE      = 8'hD5,
    parameter logic [47:0] DST_ADDR_CODE = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_ADDR_CODE = 48'h123456789ABC,
    parameter logic [15:0] MIN_PAYLOAD   = 16'd46,
    parameter logic [15:0] MAX_PAYLOAD   = 16'd1500,
    parameter logic [7:0]  IPG_WORDS     = 8'd2
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    mac_frame_generator_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_EOF, S_IPG} state_t;

    localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {CTRL_WIDTH{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] START_WORD = {SFD_CODE, {6{PREAMBLE_CODE}}, START_CODE};

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           data_end_q, data_end_d;
    logic [7:0]            seed_q, seed_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic [31:0]           crc_q, crc_d;
    logic [7:0]            ipg_cnt_q, ipg_cnt_d;
    logic [15:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;

    logic [DATA_WIDTH-1:0] gen_data;
    logic [CTRL_WIDTH-1:0] gen_ctrl;
    logic [31:0]           gen_crc;
    logic [15:0]           gen_b;
    logic [7:0]            gen_lane;
    logic                  gen_last;
    logic [15:0]           term_idx;
    logic [15:0]           len_clamp;
    logic                  ipg_done;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // The CRC chains through the lanes in order, so an FCS lane sees the value after every data byte before it.
    always_comb begin
        gen_data = '0;
        gen_ctrl = '0;
        gen_crc  = crc_q;
        gen_b    = '0;
        gen_lane = '0;
        term_idx = data_end_q + 16'd4;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            gen_b    = {5'd0, word_cnt_q, 3'(i)};
            gen_lane = 8'h00;
            if (gen_b >= term_idx) begin
                gen_ctrl[i] = 1'b1;
                gen_lane    = (gen_b == term_idx) ? TERM_CODE : IDLE_CODE;
            end else if (gen_b >= data_end_q) begin
                gen_lane = 8'(~gen_crc >> {gen_b - data_end_q, 3'b000});
            end else if (gen_b < 16'd14) begin
                gen_lane = 8'(DST_ADDR_CODE >> {gen_b - 16'd8, 3'b000});
            end else if (gen_b < 16'd20) begin
                gen_lane = 8'(SRC_ADDR_CODE >> {gen_b - 16'd14, 3'b000});
            end else if (gen_b == 16'd20) begin
                gen_lane = len_q[7:0];
            end else if (gen_b == 16'd21) begin
                gen_lane = len_q[15:8];
            end else if (gen_b < 16'd22 + len_q) begin
                gen_lane = seed_q + 8'(gen_b - 16'd22);
            end
            if (gen_b < data_end_q) begin
                gen_crc = crc32_byte(gen_crc, gen_lane);
            end
            gen_data[8*i +: 8] = gen_lane;
        end
        gen_last = (term_idx[15:3] == {5'd0, word_cnt_q});
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        data_end_d = data_end_q;
        seed_d     = seed_q;
        word_cnt_d = word_cnt_q;
        crc_d      = crc_q;
        ipg_cnt_d  = ipg_cnt_q;
        count_d    = count_q;
        data_d     = IDLE_WORD;
        ctrl_d     = '1;
        ipg_done   = 1'b0;
        len_clamp  = (bus.i_payload_len > MAX_PAYLOAD) ? MAX_PAYLOAD : bus.i_payload_len;
        case (state_q)
            S_IDLE: ;
            S_SOF, S_DATA: begin
                data_d     = gen_data;
                ctrl_d     = gen_ctrl;
                crc_d      = gen_crc;
                word_cnt_d = word_cnt_q + 8'd1;
                if (gen_last) begin
                    state_d = S_EOF;
                    count_d = count_q + 16'd1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_EOF: begin
                state_d   = S_IPG;
                ipg_cnt_d = '0;
            end
            S_IPG: begin
                if (ipg_cnt_q == IPG_WORDS - 8'd1) begin
                    state_d  = S_IDLE;
                    ipg_done = 1'b1;
                end else begin
                    ipg_cnt_d = ipg_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The edge that completes the IPG may accept the next start directly.
        if ((state_q == S_IDLE || ipg_done) && bus.i_start) begin
            state_d    = S_SOF;
            len_d      = len_clamp;
            data_end_d = 16'd22 + ((len_clamp < MIN_PAYLOAD) ? MIN_PAYLOAD : len_clamp);
            seed_d     = bus.i_seed;
            word_cnt_d = 8'd1;
            crc_d      = 32'hFFFFFFFF;
            data_d     = START_WORD;
            ctrl_d     = 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            data_end_q <= '0;
            seed_q     <= '0;
            word_cnt_q <= '0;
            crc_q      <= '0;
            ipg_cnt_q  <= '0;
            count_q    <= '0;
            data_q     <= IDLE_WORD;
            ctrl_q     <= '1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            data_end_q <= data_end_d;
            seed_q     <= seed_d;
            word_cnt_q <= word_cnt_d;
            crc_q      <= crc_d;
            ipg_cnt_q  <= ipg_cnt_d;
            count_q    <= count_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign bus.o_tx_data     = data_q;
    assign bus.o_tx_ctrl     = ctrl_q;
    assign bus.o_data_valid  = (state_q == S_SOF) || (state_q == S_DATA) || (state_q == S_EOF);
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_frame_done  = (state_q == S_EOF);
    assign bus.o_frame_count = count_q;

endmodule
